snake_body_engine: RTL and testbench

- Owns the snake body and the occupancy map. It writes the map; the movement logic reads it.
- Acts as the responder to the main state machine's setUpGo, moveGo and spawnGo pulses.
- Returns setUpDone, a 2-bit move result (feeds movementLogic) and spawnDone.
- Keeps the body as a circular coordinate buffer and places food from the random X/Y generators.

---
 rtl/snake_body_engine.sv | 196 +++++++++++++++++++
 tb/tb_snake_body_engine.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_body_engine.sv
// Snake body engine: circular body buffer, occupancy map, move resolution and food placement.
// Define SNAKE_WRAP_EN to make the grid edges wrap instead of reporting wall hits.
module snake_body_engine #(
  parameter int GRID_W    = 12,
  parameter int GRID_H    = 9,
  parameter int MAX_LEN   = 32,
  parameter int START_X   = 5,
  parameter int START_Y   = 4,
  parameter int START_LEN = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       setUpGo,
  input  logic                       moveGo,
  input  logic                       spawnGo,
  input  logic [1:0]                 nextMove,
  input  logic [3:0]                 randX,
  input  logic [3:0]                 randY,
  output logic                       setUpDone,
  output logic                       moveDone,
  output logic [1:0]                 moveResult,
  output logic                       spawnDone,
  output logic [GRID_W*GRID_H-1:0]   mapFlat,
  output logic [3:0]                 headX,
  output logic [3:0]                 headY,
  output logic [3:0]                 foodX,
  output logic [3:0]                 foodY,
  output logic                       foodValid,
  output logic [5:0]                 length
);
  localparam int CELLS = GRID_W * GRID_H;
  localparam int IDXW  = $clog2(CELLS);
  localparam int PW    = $clog2(MAX_LEN);
`ifdef SNAKE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, INIT_CLR, INIT_BODY, READY, MOVE_CALC, MOVE_COMMIT, SPAWN_TRY, SPAWN_SCAN
  } state_t;

  state_t        state;
  logic [3:0]    bodyX [MAX_LEN];
  logic [3:0]    bodyY [MAX_LEN];
  logic [PW-1:0] headPtr, tailPtr, initCnt;
  logic [3:0]    candX, candY, tryCnt, scanX, scanY;
  logic          candWall;

  function automatic logic [IDXW-1:0] cellIdx(input logic [3:0] x, input logic [3:0] y);
    return IDXW'(int'(y) * GRID_W + int'(x));
  endfunction

  function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
    return (int'(p) == MAX_LEN - 1) ? '0 : p + 1'b1;
  endfunction

  // Step always produces the wrapped coordinate; edgeHit says whether an edge was crossed.
  logic [3:0] stepX, stepY;
  logic       edgeHit;
  always_comb begin
    stepX   = headX;
    stepY   = headY;
    edgeHit = 1'b0;
    case (nextMove)
      2'b00: begin edgeHit = (headY == 4'd0);               stepY = edgeHit ? 4'(GRID_H-1) : headY - 4'd1; end
      2'b01: begin edgeHit = (int'(headY) == GRID_H - 1);   stepY = edgeHit ? 4'd0 : headY + 4'd1;         end
      2'b10: begin edgeHit = (headX == 4'd0);               stepX = edgeHit ? 4'(GRID_W-1) : headX - 4'd1; end
      default: begin edgeHit = (int'(headX) == GRID_W - 1); stepX = edgeHit ? 4'd0 : headX + 4'd1;         end
    endcase
  end

  logic [3:0] tailX, tailY, initX;
  logic       candFood, popTail, selfHit, randFree, scanFree;
  assign tailX    = bodyX[tailPtr];
  assign tailY    = bodyY[tailPtr];
  assign initX    = 4'(START_X - START_LEN + 1 + int'(initCnt));
  assign candFood = foodValid && candX == foodX && candY == foodY;
  // The tail only vacates its cell when the snake does not grow.
  assign popTail  = !candFood || (int'(length) == MAX_LEN);
  assign selfHit  = mapFlat[cellIdx(candX, candY)] && !(popTail && candX == tailX && candY == tailY);
  assign randFree = (int'(randX) < GRID_W) && (int'(randY) < GRID_H) &&
                    !mapFlat[cellIdx(randX, randY)] && !(randX == headX && randY == headY);
  assign scanFree = !mapFlat[cellIdx(scanX, scanY)] && !(scanX == headX && scanY == headY);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      {setUpDone, moveDone, spawnDone, moveResult, foodValid} <= '0;
      mapFlat <= '0;
      {headX, headY, foodX, foodY, length} <= '0;
      {headPtr, tailPtr, initCnt} <= '0;
      {candX, candY, candWall, tryCnt, scanX, scanY} <= '0;
    end else begin
      setUpDone <= 1'b0;
      moveDone  <= 1'b0;
      spawnDone <= 1'b0;
      case (state)
        IDLE, READY: begin
          if (setUpGo) begin
            mapFlat   <= '0;
            foodValid <= 1'b0;
            length    <= '0;
            state     <= INIT_CLR;
          end else if (state == READY && moveGo) begin
            candX    <= stepX;
            candY    <= stepY;
            candWall <= edgeHit && !WRAP;
            state    <= MOVE_CALC;
          end else if (state == READY && spawnGo) begin
            tryCnt <= '0;
            state  <= SPAWN_TRY;
          end
        end
        INIT_CLR: begin
          headPtr <= '0;
          tailPtr <= '0;
          initCnt <= '0;
          state   <= INIT_BODY;
        end
        INIT_BODY: begin
          bodyX[initCnt] <= initX;
          bodyY[initCnt] <= 4'(START_Y);
          mapFlat[cellIdx(initX, 4'(START_Y))] <= 1'b1;
          headPtr <= initCnt;
          initCnt <= initCnt + 1'b1;
          if (int'(initCnt) == START_LEN - 1) begin
            headX     <= 4'(START_X);
            headY     <= 4'(START_Y);
            length    <= 6'(START_LEN);
            setUpDone <= 1'b1;
            state     <= READY;
          end
        end
        MOVE_CALC: begin
          moveDone <= 1'b1;
          state    <= MOVE_COMMIT;
          if (candWall)     moveResult <= 2'b10;
          else if (selfHit) moveResult <= 2'b11;
          else begin
            // Tail clear precedes head set so a head entering the vacated cell keeps its bit.
            if (popTail) begin
              mapFlat[cellIdx(tailX, tailY)] <= 1'b0;
              tailPtr <= ptrInc(tailPtr);
            end
            mapFlat[cellIdx(candX, candY)] <= 1'b1;
            bodyX[ptrInc(headPtr)] <= candX;
            bodyY[ptrInc(headPtr)] <= candY;
            headPtr <= ptrInc(headPtr);
            headX   <= candX;
            headY   <= candY;
            if (candFood) begin
              moveResult <= 2'b01;
              foodValid  <= 1'b0;
              if (!popTail) length <= length + 6'd1;
            end else begin
              moveResult <= 2'b00;
            end
          end
        end
        MOVE_COMMIT: state <= READY;
        SPAWN_TRY: begin
          if (randFree) begin
            foodX     <= randX;
            foodY     <= randY;
            foodValid <= 1'b1;
            spawnDone <= 1'b1;
            state     <= READY;
          end else if (tryCnt == 4'd15) begin
            scanX <= '0;
            scanY <= '0;
            state <= SPAWN_SCAN;
          end else begin
            tryCnt <= tryCnt + 4'd1;
          end
        end
        SPAWN_SCAN: begin
          if (scanFree) begin
            foodX     <= scanX;
            foodY     <= scanY;
            foodValid <= 1'b1;
            spawnDone <= 1'b1;
            state     <= READY;
          end else if (int'(scanX) == GRID_W - 1) begin
            scanX <= '0;
            scanY <= scanY + 4'd1;
          end else begin
            scanX <= scanX + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_snake_body_engine.sv
// Scoreboard bench for snake_body_engine: a queue-based body model predicts each move result.
module tb_snake_body_engine;
  localparam int W = 12, H = 9, CELLS = W * H;

  logic clk = 1'b0, reset = 1'b1;
  logic setUpGo = 1'b0, moveGo = 1'b0, spawnGo = 1'b0;
  logic [1:0] nextMove = 2'b00;
  logic [3:0] randX = 4'd0, randY = 4'd0;
  logic setUpDone, moveDone, spawnDone, foodValid;
  logic [1:0] moveResult;
  logic [CELLS-1:0] mapFlat;
  logic [3:0] headX, headY, foodX, foodY;
  logic [5:0] length;

  snake_body_engine dut (
    .clk(clk), .reset(reset), .setUpGo(setUpGo), .moveGo(moveGo), .spawnGo(spawnGo),
    .nextMove(nextMove), .randX(randX), .randY(randY), .setUpDone(setUpDone),
    .moveDone(moveDone), .moveResult(moveResult), .spawnDone(spawnDone), .mapFlat(mapFlat),
    .headX(headX), .headY(headY), .foodX(foodX), .foodY(foodY), .foodValid(foodValid),
    .length(length)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] res;
    logic [3:0] hx;
    logic [3:0] hy;
    logic [5:0] len;
  } mv_t;

  int total = 0, bad = 0;
  mv_t mvQ[$];
  mv_t monExp;
  int qx[$], qy[$];
  bit mFoodValid = 1'b0;
  int mFx = 0, mFy = 0;

  // Every moveDone must match the oldest predicted move.
  always @(negedge clk) begin
    if (moveDone) begin
      total++;
      if (mvQ.size() == 0) begin
        bad++;
        $display("FAIL unexpected_moveDone got result=%0d want no pulse", moveResult);
      end else begin
        monExp = mvQ.pop_front();
        if ({moveResult, headX, headY, length} !== monExp) begin
          bad++;
          $display("FAIL move_result got res=%0d head=(%0d,%0d) len=%0d want res=%0d head=(%0d,%0d) len=%0d",
                   moveResult, headX, headY, length, monExp.res, monExp.hx, monExp.hy, monExp.len);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CELLS-1:0] modelMap();
    logic [CELLS-1:0] m = '0;
    foreach (qx[i]) m[qy[i] * W + qx[i]] = 1'b1;
    return m;
  endfunction

  task automatic modelSetup();
    qx = {3, 4, 5};
    qy = {4, 4, 4};
    mFoodValid = 1'b0;
  endtask

  task automatic modelMove(input logic [1:0] dir);
    int nx, ny;
    bit wall, occ;
    mv_t e;
    nx = qx[$];
    ny = qy[$];
    case (dir)
      2'b00: ny--;
      2'b01: ny++;
      2'b10: nx--;
      default: nx++;
    endcase
`ifdef SNAKE_WRAP_EN
    nx = (nx + W) % W;
    ny = (ny + H) % H;
    wall = 1'b0;
`else
    wall = nx < 0 || nx >= W || ny < 0 || ny >= H;
`endif
    occ = 1'b0;
    for (int i = 1; i < qx.size(); i++) if (qx[i] == nx && qy[i] == ny) occ = 1'b1;
    if (wall) e.res = 2'b10;
    else if (occ) e.res = 2'b11;
    else if (mFoodValid && nx == mFx && ny == mFy) begin
      e.res = 2'b01;
      mFoodValid = 1'b0;
      qx.push_back(nx);
      qy.push_back(ny);
      if (qx.size() > 32) begin
        void'(qx.pop_front());
        void'(qy.pop_front());
      end
    end else begin
      e.res = 2'b00;
      void'(qx.pop_front());
      void'(qy.pop_front());
      qx.push_back(nx);
      qy.push_back(ny);
    end
    e.hx = 4'(qx[$]);
    e.hy = 4'(qy[$]);
    e.len = 6'(qx.size());
    mvQ.push_back(e);
  endtask

  task automatic doMove(input logic [1:0] dir, output logic d1, output logic d2);
    modelMove(dir);
    @(negedge clk);
    moveGo = 1'b1;
    nextMove = dir;
    tick();
    moveGo = 1'b0;
    d1 = moveDone;
    tick();
    d2 = moveDone;
    tick();
  endtask

  task automatic test_reset();
    tick();
    tick();
    total++;
    if ({setUpDone, moveDone, spawnDone, moveResult, mapFlat, headX, headY, foodX, foodY, foodValid, length} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got map=%h head=(%0d,%0d) len=%0d want all zero", mapFlat, headX, headY, length);
    end
    reset = 1'b0;
    // moveGo in IDLE must be ignored
    @(negedge clk);
    moveGo = 1'b1;
    tick();
    moveGo = 1'b0;
    repeat (4) tick();
    total++;
    if ({setUpDone, headX, length, mapFlat} !== '0) begin
      bad++;
      $display("FAIL idle_ignore got done=%0d len=%0d map=%h want zeros", setUpDone, length, mapFlat);
    end
  endtask

  // mode 0: plain setup; 1: moveGo together with setUpGo; 2: moveGo during INIT_BODY
  task automatic test_setup(input int mode);
    int lat;
    @(negedge clk);
    setUpGo = 1'b1;
    moveGo = (mode == 1);
    lat = 0;
    do begin
      tick();
      lat++;
      setUpGo = 1'b0;
      moveGo = (mode == 2 && lat == 2);
    end while (!setUpDone && lat < 20);
    moveGo = 1'b0;
    modelSetup();
    total++;
    if (lat !== 5) begin
      bad++;
      $display("FAIL setup_latency mode=%0d got=%0d want=5", mode, lat);
    end
    total++;
    if (mapFlat !== modelMap() || headX !== 4'd5 || headY !== 4'd4 || length !== 6'd3 || foodValid !== 1'b0) begin
      bad++;
      $display("FAIL setup_state got map=%h head=(%0d,%0d) len=%0d food=%0d want map=%h head=(5,4) len=3 food=0",
               mapFlat, headX, headY, length, foodValid, modelMap());
    end
    tick();
    total++;
    if (setUpDone !== 1'b0) begin
      bad++;
      $display("FAIL setup_pulse_width got=%0d want=0", setUpDone);
    end
  endtask

  task automatic test_self_hit();
    logic d1, d2;
    doMove(2'b10, d1, d2);
    total++;
    if (mapFlat !== modelMap() || mvQ.size() != 0) begin
      bad++;
      $display("FAIL self_hit_state got map=%h pending=%0d want map=%h pending=0", mapFlat, mvQ.size(), modelMap());
    end
  endtask

  task automatic test_move_right();
    logic d1, d2;
    doMove(2'b11, d1, d2);
    total++;
    if ({d1, d2} !== 2'b01) begin
      bad++;
      $display("FAIL move_latency got done@1=%0d done@2=%0d want 0,1", d1, d2);
    end
    total++;
    if (mapFlat !== modelMap() || mvQ.size() != 0) begin
      bad++;
      $display("FAIL move_map got map=%h pending=%0d want map=%h pending=0", mapFlat, mvQ.size(), modelMap());
    end
  endtask

  task automatic test_spawn();
    logic early, d1, d2;
    @(negedge clk);
    spawnGo = 1'b1;
    randX = 4'd15;
    randY = 4'd4;
    tick();
    spawnGo = 1'b0;
    early = spawnDone;
    tick();
    early |= spawnDone;
    randX = 4'd6;
    tick();
    early |= spawnDone;
    randX = 4'd8;
    tick();
    total++;
    if (early !== 1'b0 || spawnDone !== 1'b1) begin
      bad++;
      $display("FAIL spawn_timing got early=%0d done=%0d want early=0 done=1", early, spawnDone);
    end
    total++;
    if ({foodValid, foodX, foodY} !== {1'b1, 4'd8, 4'd4}) begin
      bad++;
      $display("FAIL spawn_food got valid=%0d (%0d,%0d) want valid=1 (8,4)", foodValid, foodX, foodY);
    end
    tick();
    total++;
    if (spawnDone !== 1'b0) begin
      bad++;
      $display("FAIL spawn_pulse_width got=%0d want=0", spawnDone);
    end
    mFoodValid = 1'b1;
    mFx = 8;
    mFy = 4;
    doMove(2'b11, d1, d2);
    doMove(2'b11, d1, d2);
    total++;
    if (length !== 6'd4 || foodValid !== 1'b0 || mapFlat !== modelMap() || mvQ.size() != 0) begin
      bad++;
      $display("FAIL eat_state got len=%0d food=%0d map=%h want len=4 food=0 map=%h", length, foodValid, mapFlat, modelMap());
    end
  endtask

  task automatic test_spawn_scan();
    int lat;
    @(negedge clk);
    spawnGo = 1'b1;
    randX = 4'd15;
    randY = 4'd15;
    lat = 0;
    do begin
      tick();
      lat++;
      spawnGo = 1'b0;
    end while (!spawnDone && lat < 40);
    total++;
    if (lat !== 18 || {foodValid, foodX, foodY} !== {1'b1, 4'd0, 4'd0}) begin
      bad++;
      $display("FAIL spawn_scan got lat=%0d valid=%0d (%0d,%0d) want lat=18 valid=1 (0,0)", lat, foodValid, foodX, foodY);
    end
    mFoodValid = 1'b1;
    mFx = 0;
    mFy = 0;
  endtask

  task automatic test_wall();
    logic d1, d2;
    repeat (3) doMove(2'b11, d1, d2);
    total++;
    if ({headX, headY} !== {4'd11, 4'd4}) begin
      bad++;
      $display("FAIL wall_approach got head=(%0d,%0d) want (11,4)", headX, headY);
    end
    doMove(2'b11, d1, d2);
    total++;
    if (mapFlat !== modelMap() || mvQ.size() != 0) begin
      bad++;
      $display("FAIL wall_map got map=%h pending=%0d want map=%h pending=0", mapFlat, mvQ.size(), modelMap());
    end
  endtask

  task automatic test_reset_mid_move();
    logic d1, d2;
    @(negedge clk);
    moveGo = 1'b1;
    nextMove = 2'b00;
    tick();
    moveGo = 1'b0;
    reset = 1'b1;
    tick();
    total++;
    if ({setUpDone, moveDone, spawnDone, moveResult, mapFlat, headX, headY, foodX, foodY, foodValid, length} !== '0) begin
      bad++;
      $display("FAIL reset_mid_move got map=%h head=(%0d,%0d) done=%0d want all zero", mapFlat, headX, headY, moveDone);
    end
    tick();
    reset = 1'b0;
    repeat (3) tick();
    test_setup(0);
    doMove(2'b11, d1, d2);
    total++;
    if (mapFlat !== modelMap() || mvQ.size() != 0) begin
      bad++;
      $display("FAIL restart_move got map=%h want map=%h", mapFlat, modelMap());
    end
  endtask

  initial begin
    test_reset();
    test_setup(0);
    test_self_hit();
    test_setup(2);
    test_move_right();
    test_spawn();
    test_spawn_scan();
    test_wall();
    test_reset_mid_move();
    test_setup(1);
    repeat (3) tick();
    total++;
    if (mvQ.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got pending=%0d want 0", mvQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
